floating_point_rounding: RTL

//  Stage5 rounding hardware for the single-precision add/sub datapath. Consumes the normalised

---
 rtl/floating_point_rounding_if.sv | 30 +++
 rtl/floating_point_rounding.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/floating_point_rounding_if.sv
// Operand/result bus for the add/sub rounding stage: valid/ready on both sides.
// slave = the rounding block's view, master = the producer/consumer side.
interface floating_point_rounding_if #(
   parameter int DATA_WIDTH = 32,
   parameter int MENT_WIDTH = 23,
   parameter int EXPO_WIDTH = 8
);
   logic                  valid_in;
   logic                  ready_out;
   logic                  sign_in;
   logic [EXPO_WIDTH-1:0] exponent_in;
   logic [MENT_WIDTH:0]   mentissa_in;
   logic [2:0]            grs_in;
   logic [1:0]            round_mode_in;
   logic [DATA_WIDTH-1:0] floating_out;
   logic                  valid_out;
   logic                  ready_in;
   logic                  overflow_out;
   logic                  inexact_out;

   modport slave (
      input  valid_in, sign_in, exponent_in, mentissa_in, grs_in, round_mode_in, ready_in,
      output ready_out, floating_out, valid_out, overflow_out, inexact_out
   );

   modport master (
      output valid_in, sign_in, exponent_in, mentissa_in, grs_in, round_mode_in, ready_in,
      input  ready_out, floating_out, valid_out, overflow_out, inexact_out
   );
endinterface

// File: rtl/floating_point_rounding.sv
// Stage-5 IEEE-754 rounding for the single-precision add/sub path, 2-stage valid/ready pipeline.
// Define FP_ROUND_MODES_EN to honour round_mode_in (RNE/RTZ/+inf/-inf); otherwise RNE only.
module floating_point_rounding #(
   parameter int DATA_WIDTH = 32,
   parameter int MENT_WIDTH = 23,
   parameter int EXPO_WIDTH = 8
) (
   input logic                     clk_in,
   input logic                     rst_in,
   floating_point_rounding_if.slave bus
);

   logic s1_adv;
   logic s2_adv;

   logic                  s1_valid_q,   s1_valid_d;
   logic                  s1_sign_q,    s1_sign_d;
   logic [EXPO_WIDTH-1:0] s1_exp_q,     s1_exp_d;
   logic [MENT_WIDTH:0]   s1_ment_q,    s1_ment_d;
   logic                  s1_inc_q,     s1_inc_d;
   logic                  s1_inexact_q, s1_inexact_d;

   logic                  s2_valid_q,   s2_valid_d;
   logic [DATA_WIDTH-1:0] s2_float_q,   s2_float_d;
   logic                  s2_ovf_q,     s2_ovf_d;
   logic                  s2_inexact_q, s2_inexact_d;

   logic                  grs_any;
   logic                  inc_rne;
   logic                  inc_raw;
   logic                  is_inf_nan;
   logic                  is_zero;

   logic [MENT_WIDTH:0]   low_sum;
   logic                  carry;
   logic [EXPO_WIDTH-1:0] exp_inc;
   logic                  ovf;

   always_comb begin
      s2_adv        = !s2_valid_q || bus.ready_in;
      s1_adv        = !s1_valid_q || s2_adv;
      bus.ready_out = s1_adv && !rst_in;
   end

   always_comb begin
      grs_any    = |bus.grs_in;
      inc_rne    = bus.grs_in[2] && (bus.grs_in[1] || bus.grs_in[0] || bus.mentissa_in[0]);
      is_inf_nan = &bus.exponent_in;
      is_zero    = (bus.exponent_in == '0) && (bus.mentissa_in == '0);
`ifdef FP_ROUND_MODES_EN
      case (bus.round_mode_in)
         2'b00:   inc_raw = inc_rne;
         2'b01:   inc_raw = 1'b0;
         2'b10:   inc_raw = !bus.sign_in && grs_any;
         default: inc_raw = bus.sign_in && grs_any;
      endcase
`else
      inc_raw = inc_rne;
`endif
   end

   // Specials bypass rounding by suppressing the increment; inf/NaN also report exact.
   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_sign_d    = s1_sign_q;
      s1_exp_d     = s1_exp_q;
      s1_ment_d    = s1_ment_q;
      s1_inc_d     = s1_inc_q;
      s1_inexact_d = s1_inexact_q;
      if (s1_adv) begin
         s1_valid_d = bus.valid_in;
         if (bus.valid_in) begin
            s1_sign_d    = bus.sign_in;
            s1_exp_d     = bus.exponent_in;
            s1_ment_d    = bus.mentissa_in;
            s1_inc_d     = inc_raw && !is_inf_nan && !is_zero;
            s1_inexact_d = grs_any && !is_inf_nan;
         end
      end
   end

   // The field add carries into the hidden bit; it only overflows the mantissa when the
   // hidden bit was already set, which is the same carry as the full (MENT_WIDTH+2)-bit sum.
   always_comb begin
      low_sum = {1'b0, s1_ment_q[MENT_WIDTH-1:0]} + {{MENT_WIDTH{1'b0}}, s1_inc_q};
      carry   = low_sum[MENT_WIDTH] && s1_ment_q[MENT_WIDTH];
      exp_inc = s1_exp_q + {{(EXPO_WIDTH-1){1'b0}}, 1'b1};
      ovf     = carry && (&exp_inc);
   end

   always_comb begin
      s2_valid_d   = s2_valid_q;
      s2_float_d   = s2_float_q;
      s2_ovf_d     = s2_ovf_q;
      s2_inexact_d = s2_inexact_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            if (ovf) begin
               s2_float_d = {s1_sign_q, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}};
            end else if (carry) begin
               s2_float_d = {s1_sign_q, exp_inc, {MENT_WIDTH{1'b0}}};
            end else begin
               s2_float_d = {s1_sign_q, s1_exp_q, low_sum[MENT_WIDTH-1:0]};
            end
            s2_ovf_d     = ovf;
            s2_inexact_d = s1_inexact_q || ovf;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s1_valid_q   <= 1'b0;
         s1_sign_q    <= 1'b0;
         s1_exp_q     <= '0;
         s1_ment_q    <= '0;
         s1_inc_q     <= 1'b0;
         s1_inexact_q <= 1'b0;
         s2_valid_q   <= 1'b0;
         s2_float_q   <= '0;
         s2_ovf_q     <= 1'b0;
         s2_inexact_q <= 1'b0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_sign_q    <= s1_sign_d;
         s1_exp_q     <= s1_exp_d;
         s1_ment_q    <= s1_ment_d;
         s1_inc_q     <= s1_inc_d;
         s1_inexact_q <= s1_inexact_d;
         s2_valid_q   <= s2_valid_d;
         s2_float_q   <= s2_float_d;
         s2_ovf_q     <= s2_ovf_d;
         s2_inexact_q <= s2_inexact_d;
      end
   end

   always_comb begin
      bus.valid_out    = s2_valid_q;
      bus.floating_out = s2_float_q;
      bus.overflow_out = s2_ovf_q;
      bus.inexact_out  = s2_inexact_q;
   end

endmodule
